// File: rtl/mmio_uart_pkg.sv
// Shared register map, status bit positions, FSM state types and the bit-period
// helper for the memory-mapped UART.
package mmio_uart_pkg;

  localparam logic [1:0] UART_DATA   = 2'd0;
  localparam logic [1:0] UART_STATUS = 2'd1;
  localparam logic [1:0] UART_DIV    = 2'd2;

  localparam int ST_TXFULL     = 0;
  localparam int ST_TXEMPTY    = 1;
  localparam int ST_TXBUSY     = 2;
  localparam int ST_RXVALID    = 3;
  localparam int ST_RXOVERRUN  = 4;
  localparam int ST_RXFRAMEERR = 5;

  typedef enum logic [1:0] {TIDLE = 2'd0, TSTART = 2'd1, TDATA = 2'd2, TSTOP = 2'd3} txState_t;
  typedef enum logic [1:0] {RIDLE = 2'd0, RSTART = 2'd1, RDATA = 2'd2, RSTOP = 2'd3} rxState_t;

  // Divisors below 2 would leave no room for a half-bit sample point.
  function automatic logic [15:0] bitPeriod(input logic [15:0] div);
    return (div < 16'd2) ? 16'd2 : div;
  endfunction

endpackage

// File: rtl/mmio_uart_fifo.sv
// Synchronous FIFO with extra-bit pointers; a push on a full FIFO succeeds only
// when a pop happens in the same cycle.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wrPtr;
  logic [AW:0]      rdPtr;
  logic             doPush;
  logic             doPop;

  assign doPop  = pop & ~empty;
  assign doPush = push & (~full | doPop);
  assign empty  = (wrPtr == rdPtr);
  assign full   = (wrPtr[AW] != rdPtr[AW]) && (wrPtr[AW-1:0] == rdPtr[AW-1:0]);
  assign head   = mem[rdPtr[AW-1:0]];

  // Pointer update
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wrPtr <= '0;
      rdPtr <= '0;
    end else begin
      if (doPush) wrPtr <= wrPtr + {{AW{1'b0}}, 1'b1};
      if (doPop)  rdPtr <= rdPtr + {{AW{1'b0}}, 1'b1};
    end
  end

  // Storage write
  always_ff @(posedge clk) begin
    if (doPush) mem[wrPtr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/mmio_uart.sv
// Memory-mapped 8N1 UART: DATA/STATUS/DIVISOR registers with zero-latency reads,
// FIFO-buffered transmitter and single-register receiver.
module mmio_uart
  import mmio_uart_pkg::*;
#(
  parameter logic [31:0] BASE      = 32'h0000_F000,
  parameter int          DEPTH     = 4,
  parameter logic [15:0] DIV_RESET = 16'd868
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] memAddr,
  input  logic [15:0] memWrite,
  input  logic        memRE,
  input  logic        memWE,
  output logic        sel,
  output logic [15:0] rdata,
  output logic        txd,
  input  logic        rxd
);
  logic [1:0]  regOff;
  logic        rdAcc, wrAcc, dataRd, dataWr, statusWr, divWr;
  logic [15:0] divisor;
  logic [15:0] statusWord;

  logic        txFull, txEmpty, txPop, txTick;
  logic [7:0]  fifoHead;
  txState_t    txState;
  logic [15:0] txCnt, txPeriod;
  logic [7:0]  txShift;
  logic [2:0]  txBit;

  logic        rxS1, rxS2, rxPrev, rxFall, rxTick, rxHalf;
  rxState_t    rxState;
  logic [15:0] rxCnt, rxPeriod;
  logic [7:0]  rxShift, rxByte;
  logic [2:0]  rxBit;
  logic        rxValid, rxOverrun, rxFrameErr;

  // Only the low two bits matter once sel confirms the address is in range.
  assign sel      = (memAddr >= BASE) && (memAddr <= BASE + 32'd2);
  assign regOff   = memAddr[1:0] - BASE[1:0];
  assign rdAcc    = sel & memRE;
  assign wrAcc    = sel & memWE;
  assign dataRd   = rdAcc && (regOff == UART_DATA);
  assign dataWr   = wrAcc && (regOff == UART_DATA);
  assign statusWr = wrAcc && (regOff == UART_STATUS);
  assign divWr    = wrAcc && (regOff == UART_DIV);

  // STATUS word assembly
  always_comb begin
    statusWord                = 16'h0000;
    statusWord[ST_TXFULL]     = txFull;
    statusWord[ST_TXEMPTY]    = txEmpty;
    statusWord[ST_TXBUSY]     = (txState != TIDLE);
    statusWord[ST_RXVALID]    = rxValid;
    statusWord[ST_RXOVERRUN]  = rxOverrun;
    statusWord[ST_RXFRAMEERR] = rxFrameErr;
  end

  // Combinational read mux
  always_comb begin
    rdata = 16'h0000;
    if (rdAcc) begin
      case (regOff)
        UART_DATA:   rdata = {8'h00, rxByte};
        UART_STATUS: rdata = statusWord;
        UART_DIV:    rdata = divisor;
        default:     rdata = 16'h0000;
      endcase
    end else begin
      rdata = 16'h0000;
    end
  end

  // DIVISOR register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) divisor <= DIV_RESET;
    else if (divWr) divisor <= memWrite;
  end

  sync_fifo #(.WIDTH(8), .DEPTH(DEPTH)) txFifo (
    .clk   (clk),
    .rst   (rst),
    .push  (dataWr),
    .pop   (txPop),
    .din   (memWrite[7:0]),
    .full  (txFull),
    .empty (txEmpty),
    .head  (fifoHead)
  );

  // A pop at the end of a stop bit chains the next frame with no idle gap.
  assign txTick = (txCnt == txPeriod - 16'd1);
  assign txPop  = ((txState == TIDLE) || ((txState == TSTOP) && txTick)) && !txEmpty;

  // Transmit FSM and baud counter
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      txState  <= TIDLE;
      txd      <= 1'b1;
      txCnt    <= 16'd0;
      txPeriod <= 16'd2;
      txShift  <= 8'h00;
      txBit    <= 3'd0;
    end else begin
      case (txState)
        TIDLE: begin
          if (txPop) begin
            txState  <= TSTART;
            txd      <= 1'b0;
            txShift  <= fifoHead;
            txPeriod <= bitPeriod(divisor);
            txCnt    <= 16'd0;
          end
        end
        TSTART: begin
          if (txTick) begin
            txCnt   <= 16'd0;
            txd     <= txShift[0];
            txShift <= {1'b0, txShift[7:1]};
            txBit   <= 3'd0;
            txState <= TDATA;
          end else begin
            txCnt <= txCnt + 16'd1;
          end
        end
        TDATA: begin
          if (txTick) begin
            txCnt <= 16'd0;
            if (txBit == 3'd7) begin
              txd     <= 1'b1;
              txState <= TSTOP;
            end else begin
              txd     <= txShift[0];
              txShift <= {1'b0, txShift[7:1]};
              txBit   <= txBit + 3'd1;
            end
          end else begin
            txCnt <= txCnt + 16'd1;
          end
        end
        TSTOP: begin
          if (txTick) begin
            txCnt <= 16'd0;
            if (txPop) begin
              txState  <= TSTART;
              txd      <= 1'b0;
              txShift  <= fifoHead;
              txPeriod <= bitPeriod(divisor);
            end else begin
              txState <= TIDLE;
            end
          end else begin
            txCnt <= txCnt + 16'd1;
          end
        end
        default: begin
          txState <= TIDLE;
          txd     <= 1'b1;
        end
      endcase
    end
  end

  // rxd synchronizer plus one history flop for edge detection
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rxS1   <= 1'b1;
      rxS2   <= 1'b1;
      rxPrev <= 1'b1;
    end else begin
      rxS1   <= rxd;
      rxS2   <= rxS1;
      rxPrev <= rxS2;
    end
  end

  assign rxFall = rxPrev & ~rxS2;
  assign rxTick = (rxCnt == rxPeriod - 16'd1);
  assign rxHalf = (rxCnt == (rxPeriod >> 1) - 16'd1);

  // Receive FSM, holding register and error flags; completion overrides clears.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rxState    <= RIDLE;
      rxCnt      <= 16'd0;
      rxPeriod   <= 16'd2;
      rxShift    <= 8'h00;
      rxBit      <= 3'd0;
      rxByte     <= 8'h00;
      rxValid    <= 1'b0;
      rxOverrun  <= 1'b0;
      rxFrameErr <= 1'b0;
    end else begin
      if (dataRd && rxValid) rxValid <= 1'b0;
      if (statusWr && memWrite[ST_RXOVERRUN]) rxOverrun <= 1'b0;
      if (statusWr && memWrite[ST_RXFRAMEERR]) rxFrameErr <= 1'b0;
      case (rxState)
        RIDLE: begin
          if (rxFall) begin
            rxState  <= RSTART;
            rxCnt    <= 16'd0;
            rxPeriod <= bitPeriod(divisor);
          end
        end
        RSTART: begin
          if (rxHalf) begin
            rxCnt   <= 16'd0;
            rxBit   <= 3'd0;
            rxState <= rxS2 ? RIDLE : RDATA;
          end else begin
            rxCnt <= rxCnt + 16'd1;
          end
        end
        RDATA: begin
          if (rxTick) begin
            rxCnt   <= 16'd0;
            rxShift <= {rxS2, rxShift[7:1]};
            if (rxBit == 3'd7) rxState <= RSTOP;
            else rxBit <= rxBit + 3'd1;
          end else begin
            rxCnt <= rxCnt + 16'd1;
          end
        end
        RSTOP: begin
          if (rxTick) begin
            rxCnt   <= 16'd0;
            rxState <= RIDLE;
            if (!rxS2) begin
              rxFrameErr <= 1'b1;
            end else if (!rxValid || dataRd) begin
              rxByte  <= rxShift;
              rxValid <= 1'b1;
            end else begin
              rxOverrun <= 1'b1;
            end
          end else begin
            rxCnt <= rxCnt + 16'd1;
          end
        end
        default: rxState <= RIDLE;
      endcase
    end
  end

endmodule
